// File: rtl/sd_block_streamer.sv
// Sequential SD sector reader: captures each 512-byte sector into a buffer and
// replays it as a valid/ready byte stream. Define STREAMER_TIMEOUT_EN for the FILL watchdog.
module sd_block_streamer #(
  parameter logic [31:0] START_BLK   = 32'h2000,
  parameter logic [31:0] BLK_LIMIT   = 32'd1024,
  parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        init_finished,
  output logic        rd_req,
  output logic [31:0] block_addr,
  input  logic [7:0]  sd_dout,
  input  logic        sd_valid,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic [31:0] m_blk,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, REQ, FILL, DRAIN} state_t;
  state_t state_reg, state_next;

  logic [31:0] cur_blk_reg, sec_cnt_reg;
  logic [8:0]  wr_ptr_reg;
  logic [9:0]  rd_cnt_reg;
  logic        stop_pending_reg, done_reg, err_reg;
  logic        q_valid_reg, q_last_reg;
  logic [7:0]  mem [0:511];
  logic [7:0]  ram_q;
  logic        done_next, err_next, blk_adv, begin_run;
  logic        stop_any, wr_en, last_wr, limit_hit, timeout;
  logic        draining, out_load, rd_en;

  assign stop_any  = stop | stop_pending_reg;
  assign wr_en     = (state_reg == FILL) && sd_valid;
  assign last_wr   = wr_en && (wr_ptr_reg == 9'd511);
  assign limit_hit = (BLK_LIMIT != 32'd0) && (sec_cnt_reg + 32'd1 == BLK_LIMIT);

`ifdef STREAMER_TIMEOUT_EN
  logic [31:0] wd_cnt_reg;
  assign timeout = (state_reg == FILL) && !sd_valid && (wd_cnt_reg == TIMEOUT_CYC - 32'd1);
  always_ff @(posedge clk) begin
    if (reset || state_reg != FILL || sd_valid) wd_cnt_reg <= '0;
    else wd_cnt_reg <= wd_cnt_reg + 32'd1;
  end
`else
  // No watchdog: FILL waits forever; the term only keeps the parameter referenced.
  assign timeout = 1'b0 & (TIMEOUT_CYC != 32'd0);
`endif

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    blk_adv    = 1'b0;
    begin_run  = 1'b0;
    case (state_reg)
      IDLE: if (start && init_finished) begin
        state_next = REQ;
        begin_run  = 1'b1;
      end
      REQ: state_next = FILL;
      FILL: if (timeout) begin
        state_next = IDLE;
        err_next   = 1'b1;
      end else if (last_wr) begin
        // The controller cannot be aborted, so a stop only takes effect once the sector is in.
        if (stop_any) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = DRAIN;
        end
      end
      DRAIN: if (stop_any) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end else if (m_valid && m_ready && m_last) begin
        if (limit_hit) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = REQ;
          blk_adv    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      cur_blk_reg      <= START_BLK;
      sec_cnt_reg      <= '0;
      wr_ptr_reg       <= '0;
      stop_pending_reg <= 1'b0;
      done_reg         <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      state_reg        <= state_next;
      done_reg         <= done_next;
      err_reg          <= err_next;
      // Cleared in IDLE so a stop coinciding with start is dropped.
      stop_pending_reg <= (state_reg != IDLE) && (state_next != IDLE) && stop_any;
      if (begin_run) begin
        cur_blk_reg <= START_BLK;
        sec_cnt_reg <= '0;
      end else if (blk_adv) begin
        cur_blk_reg <= cur_blk_reg + 32'd1;
        sec_cnt_reg <= sec_cnt_reg + 32'd1;
      end
      if (state_reg == REQ) wr_ptr_reg <= '0;
      else if (wr_en) wr_ptr_reg <= wr_ptr_reg + 9'd1;
    end
  end

  // Replay path: registered RAM read feeds a one-entry stage ahead of the output register.
  assign draining = (state_reg == DRAIN) && (state_next == DRAIN);
  assign out_load = !m_valid || m_ready;
  assign rd_en    = draining && !rd_cnt_reg[9] && (!q_valid_reg || out_load);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= sd_dout;
    if (rd_en) ram_q <= mem[rd_cnt_reg[8:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_data      <= '0;
      m_blk       <= '0;
      q_valid_reg <= 1'b0;
      q_last_reg  <= 1'b0;
      rd_cnt_reg  <= '0;
    end else if (draining) begin
      if (rd_en) begin
        rd_cnt_reg <= rd_cnt_reg + 10'd1;
        q_last_reg <= (rd_cnt_reg == 10'd511);
      end
      q_valid_reg <= rd_en || (q_valid_reg && !out_load);
      if (out_load) begin
        m_valid <= q_valid_reg;
        m_last  <= q_valid_reg && q_last_reg;
        if (q_valid_reg) begin
          m_data <= ram_q;
          m_blk  <= cur_blk_reg;
        end
      end
    end else begin
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      q_valid_reg <= 1'b0;
      rd_cnt_reg  <= '0;
    end
  end

  assign rd_req     = (state_reg == REQ);
  assign block_addr = cur_blk_reg;
  assign busy       = (state_reg != IDLE);
  assign done       = done_reg;
  assign err        = err_reg;
endmodule

// File: tb/tb_sd_block_streamer.sv
// Randomized self-checking bench for sd_block_streamer with an SD controller model
// and a scoreboard of the expected byte stream (block sequence from START, byte = blk^index).
module tb_sd_block_streamer;
  localparam logic [31:0] START = 32'h2000;
  localparam int SECT = 512;

  logic clk = 1'b0;
  logic reset, start, stop, init_finished, rd_req, sd_valid, m_valid, m_ready, m_last, busy, done, err;
  logic [31:0] block_addr, m_blk;
  logic [7:0]  sd_dout, m_data;

  sd_block_streamer #(.START_BLK(START), .BLK_LIMIT(32'd2), .TIMEOUT_CYC(32'd100)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .init_finished(init_finished),
    .rd_req(rd_req), .block_addr(block_addr), .sd_dout(sd_dout), .sd_valid(sd_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_blk(m_blk),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  bit reset_req, start_req, stop_req, ready_rand;
  int stop_at_byte = -1, stop_at_fill = -1;
  bit ctl_active;
  logic [31:0] ctl_addr;
  int ctl_idx, ctl_delay, ctl_stall_at = -1, ctl_gap_at = -1, ctl_gap, last_sdv_cyc;
  logic [7:0]  got_data[$];
  bit          got_last[$];
  logic [31:0] got_blk[$];
  logic [31:0] rd_addrs[$];
  int lat[$];
  int done_cnt, err_cnt, valid_cyc, unstable, rdreq_long, fill_end_cyc, err_cyc;
  bit prev_hold, prev_rdreq, prev_valid, prev_last;
  logic [7:0]  prev_data;
  logic [31:0] prev_blk;

  function automatic logic [31:0] exp_blk(int k);
    return START + 32'(k / SECT);
  endfunction
  function automatic logic [7:0] exp_byte(int k);
    logic [31:0] b;
    b = exp_blk(k);
    return b[7:0] ^ 8'(k % SECT);
  endfunction
  function automatic bit exp_last(int k);
    return (k % SECT) == SECT - 1;
  endfunction

  // One cycle: observe outputs at the falling edge, then drive the next inputs.
  task automatic step();
    bit rdy;
    @(negedge clk);
    cyc++;
    if (done) done_cnt++;
    if (err) begin err_cnt++; err_cyc = cyc; end
    if (m_valid) valid_cyc++;
    if (prev_hold && (!m_valid || m_data !== prev_data || m_last !== prev_last || m_blk !== prev_blk))
      unstable++;
    if (rd_req && prev_rdreq) rdreq_long++;
    if (rd_req && !prev_rdreq) begin
      rd_addrs.push_back(block_addr);
      ctl_active = 1; ctl_addr = block_addr; ctl_idx = 0; ctl_delay = $urandom_range(3, 1);
    end
    if (m_valid && !prev_valid && fill_end_cyc >= 0) begin
      lat.push_back(cyc - fill_end_cyc);
      fill_end_cyc = -1;
    end
    prev_rdreq = rd_req;
    prev_valid = m_valid;
    reset = reset_req;
    start = start_req; start_req = 0;
    stop = stop_req; stop_req = 0;
    rdy = ready_rand ? ($urandom_range(99) < 60) : 1'b1;
    m_ready = rdy;
    sd_valid = 1'b0;
    sd_dout = 8'($urandom);
    if (ctl_active) begin
      if (ctl_delay > 0) ctl_delay--;
      else if (ctl_idx == ctl_stall_at) begin end
      else if (ctl_gap > 0 && ctl_idx == ctl_gap_at) ctl_gap--;
      else if ($urandom_range(99) < 80) begin
        sd_valid = 1'b1;
        sd_dout = ctl_addr[7:0] ^ 8'(ctl_idx);
        if (ctl_idx == stop_at_fill) begin stop = 1'b1; stop_at_fill = -1; end
        ctl_idx++;
        last_sdv_cyc = cyc;
        if (ctl_idx == SECT) begin ctl_active = 0; fill_end_cyc = cyc; end
      end
    end else if ($urandom_range(99) < 30) begin
      sd_valid = 1'b1;
    end
    if (stop_at_byte >= 0 && m_valid && rdy && got_data.size() == stop_at_byte) begin
      stop = 1'b1; stop_at_byte = -1;
    end
    if (m_valid && rdy) begin
      got_data.push_back(m_data); got_last.push_back(m_last); got_blk.push_back(m_blk);
    end
    prev_hold = m_valid && !rdy;
    prev_data = m_data; prev_last = m_last; prev_blk = m_blk;
  endtask

  task automatic clear_mon();
    got_data.delete(); got_last.delete(); got_blk.delete(); rd_addrs.delete(); lat.delete();
    done_cnt = 0; err_cnt = 0; valid_cyc = 0; unstable = 0; rdreq_long = 0;
    fill_end_cyc = -1; err_cyc = -1; prev_hold = 0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output bit busy_at);
    ok = 0; busy_at = 1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done) begin ok = 1; busy_at = busy; break; end
    end
  endtask

  task automatic test_reset();
    reset_req = 1;
    repeat (3) step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL reset_rd_req got=%b want=0", rd_req); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
    total++; if (m_last !== 1'b0) begin bad++; $display("FAIL reset_m_last got=%b want=0", m_last); end
    total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_done_err got=%b%b want=00", done, err); end
    total++; if (block_addr !== START) begin bad++; $display("FAIL reset_block_addr got=%h want=%h", block_addr, START); end
    total++; if (m_blk !== 32'd0 || m_data !== 8'd0) begin bad++; $display("FAIL reset_m_blk_data got=%h/%h want=0/0", m_blk, m_data); end
    reset_req = 0;
    step();
    $display("test_reset: done");
  endtask

  task automatic test_init_gate();
    clear_mon();
    init_finished = 0;
    start_req = 1;
    repeat (6) step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL init_gate_busy got=%b want=0", busy); end
    total++; if (rd_addrs.size() != 0) begin bad++; $display("FAIL init_gate_rdreq got=%0d want=0", rd_addrs.size()); end
    init_finished = 1;
    step();
    $display("test_init_gate: done");
  endtask

  task automatic test_stream(input string name, input bit rand_ready, input bit poke_start);
    bit ok, busy_at;
    clear_mon();
    ready_rand = rand_ready;
    start_req = 1;
    stop_req = !poke_start;  // stop together with start from IDLE must be ignored
    if (poke_start) begin
      repeat (700) step();
      start_req = 1;         // start while busy must be ignored
    end
    wait_done(9000, ok, busy_at);
    repeat (20) step();
    total++; if (!ok) begin bad++; $display("FAIL %s_done_seen got=0 want=1", name); end
    total++; if (busy_at !== 1'b0) begin bad++; $display("FAIL %s_busy_at_done got=%b want=0", name, busy_at); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL %s_done_count got=%0d want=1", name, done_cnt); end
    total++; if (rd_addrs.size() != 2) begin bad++; $display("FAIL %s_rdreq_count got=%0d want=2", name, rd_addrs.size()); end
    for (int i = 0; i < rd_addrs.size() && i < 2; i++) begin
      total++; if (rd_addrs[i] !== START + 32'(i)) begin bad++; $display("FAIL %s_rdreq_addr%0d got=%h want=%h", name, i, rd_addrs[i], START + 32'(i)); end
    end
    total++; if (got_data.size() != 2 * SECT) begin bad++; $display("FAIL %s_byte_count got=%0d want=%0d", name, got_data.size(), 2 * SECT); end
    for (int k = 0; k < got_data.size() && k < 2 * SECT; k++) begin
      total++;
      if (got_data[k] !== exp_byte(k) || got_last[k] !== exp_last(k) || got_blk[k] !== exp_blk(k)) begin
        bad++; $display("FAIL %s_byte k=%0d got=%h/%b/%h want=%h/%b/%h", name, k,
                        got_data[k], got_last[k], got_blk[k], exp_byte(k), exp_last(k), exp_blk(k));
      end
    end
    total++; if (lat.size() != 2) begin bad++; $display("FAIL %s_latency_count got=%0d want=2", name, lat.size()); end
    foreach (lat[i]) begin
      total++; if (lat[i] != 3) begin bad++; $display("FAIL %s_first_valid_latency got=%0d want=3", name, lat[i]); end
    end
    total++; if (unstable != 0) begin bad++; $display("FAIL %s_stall_stability got=%0d want=0", name, unstable); end
    total++; if (rdreq_long != 0) begin bad++; $display("FAIL %s_rdreq_width got=%0d want=0", name, rdreq_long); end
    total++; if (err_cnt != 0) begin bad++; $display("FAIL %s_err got=%0d want=0", name, err_cnt); end
    ready_rand = 0;
    $display("test_%s: bytes=%0d", name, got_data.size());
  endtask

  task automatic test_stop_fill();
    bit ok, busy_at;
    clear_mon();
    stop_at_fill = 200;
    start_req = 1;
    wait_done(3000, ok, busy_at);
    repeat (20) step();
    total++; if (!ok || busy_at !== 1'b0) begin bad++; $display("FAIL stop_fill_done got=%b/%b want=1/0", ok, busy_at); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL stop_fill_done_count got=%0d want=1", done_cnt); end
    total++; if (valid_cyc != 0) begin bad++; $display("FAIL stop_fill_m_valid_cycles got=%0d want=0", valid_cyc); end
    total++; if (ctl_idx != SECT || ctl_active) begin bad++; $display("FAIL stop_fill_sector_complete got=%0d want=%0d", ctl_idx, SECT); end
    total++; if (rd_addrs.size() != 1) begin bad++; $display("FAIL stop_fill_rdreq_count got=%0d want=1", rd_addrs.size()); end
    $display("test_stop_fill: done");
  endtask

  task automatic test_stop_drain();
    bit ok, busy_at;
    clear_mon();
    stop_at_byte = 100;
    start_req = 1;
    wait_done(3000, ok, busy_at);
    repeat (20) step();
    total++; if (!ok || busy_at !== 1'b0) begin bad++; $display("FAIL stop_drain_done got=%b/%b want=1/0", ok, busy_at); end
    total++; if (got_data.size() != 101) begin bad++; $display("FAIL stop_drain_bytes got=%0d want=101", got_data.size()); end
    for (int k = 0; k < got_data.size(); k++) begin
      total++; if (got_data[k] !== exp_byte(k) || got_blk[k] !== exp_blk(k)) begin
        bad++; $display("FAIL stop_drain_byte k=%0d got=%h want=%h", k, got_data[k], exp_byte(k));
      end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL stop_drain_done_count got=%0d want=1", done_cnt); end
    total++; if (rd_addrs.size() != 1) begin bad++; $display("FAIL stop_drain_rdreq_count got=%0d want=1", rd_addrs.size()); end
    $display("test_stop_drain: bytes=%0d", got_data.size());
  endtask

  task automatic test_reset_mid();
    clear_mon();
    start_req = 1;
    for (int i = 0; i < 3000 && got_data.size() < 50; i++) step();
    reset_req = 1;
    repeat (2) step();
    reset_req = 0;
    ctl_active = 0;
    step();
    total++; if (busy !== 1'b0 || m_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_idle got=%b/%b want=0/0", busy, m_valid); end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL reset_mid_no_done got=%0d want=0", done_cnt); end
    test_stream("restart", 1'b0, 1'b0);
  endtask

  task automatic test_watchdog();
`ifdef STREAMER_TIMEOUT_EN
    bit busy_at;
    clear_mon();
    ctl_stall_at = 10;
    busy_at = 1;
    start_req = 1;
    for (int i = 0; i < 2000 && err_cnt == 0; i++) begin
      step();
      busy_at = busy;
    end
    repeat (20) step();
    total++; if (err_cnt != 1) begin bad++; $display("FAIL watchdog_err_count got=%0d want=1", err_cnt); end
    total++; if (err_cyc - last_sdv_cyc != 101) begin bad++; $display("FAIL watchdog_delay got=%0d want=101", err_cyc - last_sdv_cyc); end
    total++; if (busy_at !== 1'b0) begin bad++; $display("FAIL watchdog_idle got=%b want=0", busy_at); end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL watchdog_no_done got=%0d want=0", done_cnt); end
    total++; if (valid_cyc != 0) begin bad++; $display("FAIL watchdog_no_stream got=%0d want=0", valid_cyc); end
    ctl_active = 0;
    ctl_stall_at = -1;
    $display("test_watchdog: err_cycles=%0d", err_cyc - last_sdv_cyc);
`else
    ctl_gap_at = 10;
    ctl_gap = 300;
    test_stream("long_stall", 1'b0, 1'b0);
    ctl_gap_at = -1;
`endif
  endtask

  initial begin
    reset = 1; start = 0; stop = 0; init_finished = 1; sd_valid = 0; sd_dout = 0; m_ready = 1;
    reset_req = 1; start_req = 0; stop_req = 0; ready_rand = 0; ctl_active = 0; ctl_gap = 0;
    clear_mon();
    test_reset();
    test_init_gate();
    test_stream("stream", 1'b0, 1'b0);
    test_stream("backpressure", 1'b1, 1'b1);
    test_stop_fill();
    test_stop_drain();
    test_reset_mid();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
